// File: rtl/cp0_regs.sv
// cp0_regs: MIPS coprocessor-0 register file.
//   Latches exception state (EPC, Cause, Status.EXL, BadVAddr), services
//   MTC0 writes / MFC0 reads and runs the Count/Compare timer.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   we_i, waddr_i, data_i MTC0 write port (M stage)
//   raddr_i, data_o      MFC0 read port (combinational)
//   int_i                external hardware interrupt lines
//   excepttype_i         exception code (0 = none, 0xe = eret)
//   current_inst_addr_i  PC of the M-stage instruction
//   is_in_delayslot_i    M-stage instruction sits in a delay slot
//   bad_addr_i           faulting address for address-error exceptions
//   count_o .. badvaddr_o register contents for the exception logic
//   timer_int_o          timer interrupt pending
module cp0_regs #(
    parameter logic [31:0] PRID_VALUE   = 32'h00004220,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    logic tick;
    logic exc_taken;
    logic eret;
    logic mtc0;

    // Any exception or eret in the M stage squashes the MTC0 in that cycle.
    always_comb begin
        eret      = (excepttype_i == 32'he);
        exc_taken = (excepttype_i != '0) && !eret;
        mtc0      = we_i && (excepttype_i == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= 1'b0;
            count_o     <= '0;
            compare_o   <= '0;
            status_o    <= 32'h0040_0000;
            cause_o     <= '0;
            epc_o       <= '0;
            badvaddr_o  <= '0;
            timer_int_o <= 1'b0;
        end else begin
            tick <= ~tick;

            if (mtc0 && waddr_i == REG_COUNT)
                count_o <= data_i;
            else if (tick)
                count_o <= count_o + 32'd1;

            // Writing Compare acknowledges the timer; that beats a same-cycle match.
            if (mtc0 && waddr_i == REG_COMPARE) begin
                compare_o   <= data_i;
                timer_int_o <= 1'b0;
            end else if (compare_o != '0 && count_o == compare_o) begin
                timer_int_o <= 1'b1;
            end

            cause_o[15]    <= int_i[5] | timer_int_o;
            cause_o[14:10] <= int_i[4:0];

            if (exc_taken) begin
                // Nested exceptions keep the original return address and BD.
                if (!status_o[1]) begin
                    epc_o       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                     : current_inst_addr_i;
                    cause_o[31] <= is_in_delayslot_i;
                end
                status_o[1]  <= 1'b1;
                cause_o[6:2] <= (excepttype_i == 32'd1) ? 5'd0 : excepttype_i[4:0];
                if (excepttype_i == 32'd4 || excepttype_i == 32'd5)
                    badvaddr_o <= bad_addr_i;
            end else if (eret) begin
                status_o[1] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    REG_STATUS: begin
                        status_o[15:8] <= data_i[15:8];
                        status_o[1:0]  <= data_i[1:0];
                    end
                    REG_CAUSE: cause_o[9:8] <= data_i[9:8];
                    REG_EPC:   epc_o        <= data_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_o;
            REG_COUNT:    data_o = count_o;
            REG_COMPARE:  data_o = compare_o;
            REG_STATUS:   data_o = status_o;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = epc_o;
            REG_PRID:     data_o = PRID_VALUE;
            REG_CONFIG:   data_o = CONFIG_VALUE;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed scoreboard bench for cp0_regs.
//   The stimulus process pushes hand-computed expectations into a queue after
//   each rising edge; the monitor pops and compares them on the falling edge.
module tb_cp0_regs;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    cp0_regs #(
        .PRID_VALUE  (32'h00004220),
        .CONFIG_VALUE(32'h00008000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .we_i               (we_i),
        .waddr_i            (waddr_i),
        .raddr_i            (raddr_i),
        .data_i             (data_i),
        .int_i              (int_i),
        .excepttype_i       (excepttype_i),
        .current_inst_addr_i(current_inst_addr_i),
        .is_in_delayslot_i  (is_in_delayslot_i),
        .bad_addr_i         (bad_addr_i),
        .data_o             (data_o),
        .count_o            (count_o),
        .compare_o          (compare_o),
        .status_o           (status_o),
        .cause_o            (cause_o),
        .epc_o              (epc_o),
        .badvaddr_o         (badvaddr_o),
        .timer_int_o        (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_DATA     = 0;
    localparam int S_COUNT    = 1;
    localparam int S_COMPARE  = 2;
    localparam int S_STATUS   = 3;
    localparam int S_CAUSE    = 4;
    localparam int S_EPC      = 5;
    localparam int S_BADVADDR = 6;
    localparam int S_TIMER    = 7;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] expv;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_DATA:     return data_o;
            S_COUNT:    return count_o;
            S_COMPARE:  return compare_o;
            S_STATUS:   return status_o;
            S_CAUSE:    return cause_o;
            S_EPC:      return epc_o;
            S_BADVADDR: return badvaddr_o;
            default:    return {31'd0, timer_int_o};
        endcase
    endfunction

    // Monitor: drain every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c   = sb.pop_front();
            act = observe(c.sel);
            checks = checks + 1;
            if (act !== c.expv) begin
                errors = errors + 1;
                $display("FAIL %s: got %08h expected %08h", c.name, act, c.expv);
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.sel  = sel;
        c.expv = v;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        data_i  = d;
    endtask

    task automatic reset_expects(input string tag);
        expect_val({tag, "_status"},   S_STATUS,   32'h0040_0000);
        expect_val({tag, "_cause"},    S_CAUSE,    32'h0);
        expect_val({tag, "_epc"},      S_EPC,      32'h0);
        expect_val({tag, "_count"},    S_COUNT,    32'h0);
        expect_val({tag, "_compare"},  S_COMPARE,  32'h0);
        expect_val({tag, "_badvaddr"}, S_BADVADDR, 32'h0);
        expect_val({tag, "_timer"},    S_TIMER,    32'h0);
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0;
        int_i = '0; excepttype_i = '0; current_inst_addr_i = '0;
        is_in_delayslot_i = 1'b0; bad_addr_i = '0;

        step(); step();
        reset_expects("rst");

        // Timer: Compare=5, Count advances every other edge from 0.
        rst = 1'b0;
        mtc0(5'd11, 32'd5);
        step();                                     // edge 1
        we_i = 1'b0;
        expect_val("cmp_loaded", S_COMPARE, 32'd5);
        expect_val("count_e1",   S_COUNT,   32'd0);
        repeat (8) step();                          // edge 9
        expect_val("count_e9",   S_COUNT,   32'd4);
        step();                                     // edge 10
        expect_val("count_e10",  S_COUNT,   32'd5);
        expect_val("timer_e10",  S_TIMER,   32'd0);
        step();                                     // edge 11
        expect_val("timer_set",  S_TIMER,   32'd1);
        expect_val("cause_e11",  S_CAUSE,   32'h0);
        expect_val("count_e11",  S_COUNT,   32'd5);
        step();                                     // edge 12
        expect_val("cause_ip7",  S_CAUSE,   32'h0000_8000);
        expect_val("timer_hold", S_TIMER,   32'd1);
        expect_val("count_e12",  S_COUNT,   32'd6);
        mtc0(5'd11, 32'd100);
        step();                                     // edge 13
        we_i = 1'b0;
        expect_val("timer_clr",  S_TIMER,   32'd0);
        expect_val("cmp_100",    S_COMPARE, 32'd100);
        expect_val("cause_e13",  S_CAUSE,   32'h0000_8000);
        step();                                     // edge 14
        expect_val("cause_e14",  S_CAUSE,   32'h0);

        // Syscall in a delay slot with a concurrent MTC0 EPC.
        excepttype_i = 32'd8; current_inst_addr_i = 32'hbfc0_0104;
        is_in_delayslot_i = 1'b1;
        mtc0(5'd14, 32'h1234);
        step();
        we_i = 1'b0;
        expect_val("sys_epc",    S_EPC,    32'hbfc0_0100);
        expect_val("sys_cause",  S_CAUSE,  32'h8000_0020);
        expect_val("sys_status", S_STATUS, 32'h0040_0002);

        // Nested address error: EPC/BD kept, BadVAddr and ExcCode updated.
        excepttype_i = 32'd5; current_inst_addr_i = 32'h8000_0040;
        is_in_delayslot_i = 1'b0; bad_addr_i = 32'h8000_0003;
        step();
        expect_val("nest_epc",   S_EPC,      32'hbfc0_0100);
        expect_val("nest_cause", S_CAUSE,    32'h8000_0014);
        expect_val("nest_bad",   S_BADVADDR, 32'h8000_0003);
        expect_val("nest_stat",  S_STATUS,   32'h0040_0002);

        // ERET with a concurrent MTC0 Status that must be dropped.
        excepttype_i = 32'he;
        mtc0(5'd12, 32'hFFFF_FFFF);
        step();
        expect_val("eret_stat",  S_STATUS, 32'h0040_0000);
        expect_val("eret_epc",   S_EPC,    32'hbfc0_0100);
        expect_val("eret_cause", S_CAUSE,  32'h8000_0014);

        // Reset overrides a simultaneous exception and MTC0.
        rst = 1'b1; excepttype_i = 32'd8; current_inst_addr_i = 32'h100;
        mtc0(5'd14, 32'h5555);
        step();
        rst = 1'b0; excepttype_i = '0; we_i = 1'b0;
        reset_expects("rst2");
        raddr_i = 5'd15;
        expect_val("rd_prid", S_DATA, 32'h0000_4220);
        mtc0(5'd12, 32'hFFFF_FFFF);
        step();                                     // n1
        expect_val("wr_status", S_STATUS, 32'h0040_FF03);
        raddr_i = 5'd12;
        expect_val("rd_status", S_DATA,   32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        step();                                     // n2
        expect_val("wr_cause",  S_CAUSE,  32'h0000_0300);
        expect_val("count_n2",  S_COUNT,  32'd1);
        raddr_i = 5'd13;
        expect_val("rd_cause",  S_DATA,   32'h0000_0300);
        mtc0(5'd8, 32'hDEAD_BEEF);
        int_i = 6'b100001;
        step();                                     // n3
        expect_val("bad_ro",    S_BADVADDR, 32'h0);
        expect_val("cause_hw",  S_CAUSE,    32'h0000_8700);
        raddr_i = 5'd16;
        expect_val("rd_config", S_DATA,     32'h0000_8000);
        mtc0(5'd9, 32'hFFFF_FFFF);
        int_i = '0;
        step();                                     // n4
        expect_val("count_wr",  S_COUNT,  32'hFFFF_FFFF);
        expect_val("cause_n4",  S_CAUSE,  32'h0000_0300);
        raddr_i = 5'd20;
        expect_val("rd_unimpl", S_DATA,   32'h0);
        we_i = 1'b0;
        step();                                     // n5
        expect_val("count_n5",  S_COUNT,  32'hFFFF_FFFF);
        raddr_i = 5'd9;
        expect_val("rd_count",  S_DATA,   32'hFFFF_FFFF);
        excepttype_i = 32'd1; current_inst_addr_i = 32'h400;
        bad_addr_i = 32'h1234_5678;
        step();                                     // n6
        excepttype_i = '0;
        expect_val("count_wrap", S_COUNT,    32'h0);
        expect_val("int_cause",  S_CAUSE,    32'h0000_0300);
        expect_val("int_epc",    S_EPC,      32'h0);
        expect_val("int_bad",    S_BADVADDR, 32'h0);
        expect_val("int_status", S_STATUS,   32'h0040_FF03);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
